// File: rtl/npn_sweep_pkg.sv
// rtl/npn_sweep_pkg.sv - shared constants, state type and helpers for the truth-table sweeper
//
// Purpose : sizes of the characterised cell (4 inputs, 16-entry truth table),
//           sweep FSM state encoding, settle-time upper bound, and a
//           lowest-set-bit helper used by the optional comparator.
// Ports   : none (package).
package npn_sweep_pkg;

  localparam int N_IN       = 4;
  localparam int TT_W       = 16;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [N_IN-1:0] lowest_set(input logic [TT_W-1:0] v);
    lowest_set = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = N_IN'(i);
    end
  endfunction

endpackage

// File: rtl/npn_settle_timer.sv
// rtl/npn_settle_timer.sv - 4-bit settle counter with clear and terminal count
//
// Purpose : counts cycles a minterm has been held; tc marks the sample cycle
//           and the counter wraps to zero on that same edge.
// Ports   : clk      in  clock, rising edge
//           rst      in  synchronous active-high reset
//           clr      in  synchronous clear (held while not sweeping)
//           en       in  count enable
//           tc       out high in the cycle whose closing edge samples dut_y
module npn_settle_timer #(
  parameter int unsigned TERMINAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [3:0] count;

  assign tc = en && (count == 4'(TERMINAL));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/npn_tt_sweeper.sv
// rtl/npn_tt_sweeper.sv - sweeps a 4-input cell through all minterms and captures its truth table
//
// Purpose : on start, drives dut_x = 0..15, holding each value SETTLE_CYCLES
//           cycles and sampling dut_y into tt[dut_x] on the last edge of the
//           hold. done pulses for one cycle after a full sweep; abort returns
//           to idle keeping the partial table.
// Optional: macro NPN_TT_CHECK_EN adds expect_tt/match/mism_idx and the
//           comparator judged on the final sample edge.
// Ports   : clk, rst (sync active-high), start, abort, busy, done,
//           tt[15:0], dut_x[3:0], dut_y,
//           [NPN_TT_CHECK_EN] expect_tt[15:0], match, mism_idx[3:0]
module npn_tt_sweeper
  import npn_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic [N_IN-1:0] dut_x,
  input  logic            dut_y
`ifdef NPN_TT_CHECK_EN
  ,
  input  logic [TT_W-1:0] expect_tt,
  output logic            match,
  output logic [N_IN-1:0] mism_idx
`endif
);

  // Out-of-range settle values are clamped into 1..SETTLE_MAX.
  localparam int unsigned S_EFF = (SETTLE_CYCLES < 1) ? 1 :
                                  (SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES;

  state_t state, state_nxt;
  logic   sample;
  logic   last;

  npn_settle_timer #(
    .TERMINAL(S_EFF - 1)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state != RUN),
    .en (state == RUN),
    .tc (sample)
  );

  assign last = sample && (&dut_x);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

  // dut_x wraps 15 -> 0 naturally on the final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt    <= '0;
      dut_x <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tt    <= '0;
            dut_x <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            dut_x <= '0;
          end else if (sample) begin
            tt[dut_x] <= dut_y;
            dut_x     <= dut_x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NPN_TT_CHECK_EN
  // The last bit is still in flight on the final edge, so compare against
  // the table as it will be once bit 15 lands.
  logic [TT_W-1:0] tt_final;
  logic [TT_W-1:0] diff;

  assign tt_final = {dut_y, tt[TT_W-2:0]};
  assign diff     = tt_final ^ expect_tt;

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      match    <= 1'b0;
      mism_idx <= '0;
    end else if (state == RUN && !abort && last) begin
      match    <= (diff == '0);
      mism_idx <= lowest_set(diff);
    end
  end
`endif

endmodule
